// File: rtl/alu_exec_unit.sv
// alu_exec_unit: consumes the 4-bit ALU control code, executes AND/OR/ADD/SUB/PASSB
// in one cycle and returns a registered result with NZCV flags over valid/ready.
// Optional macro ALU_MUL_EN adds an iterative shift-add unsigned multiply (code 1001);
// without it, code 1001 is reported as illegal like any other unsupported code.
module alu_exec_unit #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 7
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [3:0]            iControl,
  input  logic [DATA_WIDTH-1:0] iA,
  input  logic [DATA_WIDTH-1:0] iB,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_WIDTH-1:0] oResult,
  output logic [3:0]            oFlags,
  output logic                  oIllegal
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;
  localparam int unsigned MSB   = DATA_WIDTH - 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b1000;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'b1001;
`endif

  // Reject parameter sets the counter or flag logic cannot support.
  if (DATA_WIDTH < 2 || (DATA_WIDTH >> CNT_WIDTH) != 0) begin : g_param_check
    $error("alu_exec_unit: DATA_WIDTH must be >= 2 and < 2**CNT_WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [3:0]            flags_q, flags_d;
  logic                  illegal_q, illegal_d;

`ifdef ALU_MUL_EN
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
`endif

  logic                  is_sub;
  logic [DATA_WIDTH-1:0] b_op;
  logic [SUM_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;
  logic                  alu_ovf;
  logic                  alu_ill;

  // Single-cycle datapath on the live request; SUB reuses the adder as A + ~B + 1.
  always_comb begin
    is_sub    = (iControl == OP_SUB);
    b_op      = is_sub ? ~iB : iB;
    sum       = {1'b0, iA} + {1'b0, b_op} + SUM_W'(is_sub);
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (iControl)
      OP_AND:   alu_res = iA & iB;
      OP_OR:    alu_res = iA | iB;
      OP_ADD, OP_SUB: begin
        alu_res   = sum[MSB:0];
        alu_carry = sum[DATA_WIDTH];
        alu_ovf   = (iA[MSB] == b_op[MSB]) && (sum[MSB] != iA[MSB]);
      end
      OP_PASSB: alu_res = iB;
      default:  alu_ill = 1'b1;
    endcase
  end

  // Next-state and next-output logic; handshake outputs mirror the next state.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
`ifdef ALU_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          result_d  = alu_res;
          flags_d   = {alu_res[MSB], (alu_res == '0), alu_carry, alu_ovf};
          illegal_d = alu_ill;
          state_d   = S_DONE;
`ifdef ALU_MUL_EN
          if (iControl == OP_MUL) begin
            result_d  = result_q;
            flags_d   = flags_q;
            illegal_d = illegal_q;
            mcand_d   = iA;
            mplier_d  = iB;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = S_MUL;
          end
`endif
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (cnt_q == CNT_WIDTH'(DATA_WIDTH)) begin
          result_d  = acc_q;
          flags_d   = {acc_q[MSB], (acc_q == '0), 2'b00};
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_WIDTH'(1);
        end
      end
`endif
      S_DONE: begin
        if (iReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign oReady   = ready_q;
  assign oValid   = valid_q;
  assign oResult  = result_q;
  assign oFlags   = flags_q;
  assign oIllegal = illegal_q;

endmodule
